// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: run enable in, raster timing outputs back to the renderer and sync pins
interface vga_timing_gen_if #(
  parameter int CW = 10,
  parameter int FW = 8
);
  logic i_en;
  logic o_pix_en;
  logic o_hs;
  logic o_vs;
  logic [CW-1:0] o_x;
  logic [CW-1:0] o_y;
  logic o_active;
  logic o_line_start;
  logic o_frame_start;
  logic [FW-1:0] o_frame;
  modport master (
    input  i_en,
    output o_pix_en, o_hs, o_vs, o_x, o_y, o_active, o_line_start, o_frame_start, o_frame
  );
  modport slave (
    output i_en,
    input  o_pix_en, o_hs, o_vs, o_x, o_y, o_active, o_line_start, o_frame_start, o_frame
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-enable divider, sync, coordinates and frame count
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FW       = 8
) (
  input logic clk,
  input logic rst_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  // one extra bit so a sync end equal to the total still compares correctly
  localparam logic [CW:0] H_A  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_B = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_E = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_A  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_B = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_E = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  if (H_SYNC < 1 || V_SYNC < 1 || CLK_DIV < 1 ||
      longint'(H_TOTAL) > (longint'(1) << CW) || longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad
    $fatal(1, "vga_timing_gen: invalid parameters");
  end
  logic [DW-1:0] div;
  logic step, x_wrap, y_wrap;
  logic [CW-1:0] nx, ny;
  assign step = rst_n && vif.i_en && div == DW'(CLK_DIV - 1);
  assign x_wrap = vif.o_x == CW'(H_TOTAL - 1);
  assign y_wrap = vif.o_y == CW'(V_TOTAL - 1);
  assign vif.o_pix_en = step;
  always_comb begin
    nx = x_wrap ? '0 : vif.o_x + CW'(1);
    ny = x_wrap ? (y_wrap ? '0 : vif.o_y + CW'(1)) : vif.o_y;
  end
  // sync/active are computed from the next coordinates so they land with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div               <= '0;
      vif.o_x           <= '0;
      vif.o_y           <= '0;
      vif.o_frame       <= '0;
      vif.o_active      <= 1'b1;
      vif.o_hs          <= ~HS_POL;
      vif.o_vs          <= ~VS_POL;
      vif.o_line_start  <= 1'b0;
      vif.o_frame_start <= 1'b0;
    end else begin
      vif.o_line_start  <= step && x_wrap;
      vif.o_frame_start <= step && x_wrap && y_wrap;
      if (vif.i_en) div <= step ? '0 : div + DW'(1);
      if (step) begin
        vif.o_x      <= nx;
        vif.o_y      <= ny;
        vif.o_active <= {1'b0, nx} < H_A && {1'b0, ny} < V_A;
        vif.o_hs     <= ({1'b0, nx} >= HS_B && {1'b0, nx} < HS_E) ? HS_POL : ~HS_POL;
        vif.o_vs     <= ({1'b0, ny} >= VS_B && {1'b0, ny} < VS_E) ? VS_POL : ~VS_POL;
        if (x_wrap && y_wrap) vif.o_frame <= vif.o_frame + FW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations driven sequentially; a pixel-count reference model feeds per-DUT scoreboards
module tb_vga_timing_gen;
  typedef struct packed {
    logic pe, hs, vs, act, ls, fs;
    logic [15:0] x, y, fr;
  } obs_t;
  typedef struct {
    int ht, vt, ha, va, hs0, hs1, vs0, vs1, dv, fm;
    bit hp, vp;
  } cfg_t;
  typedef struct {
    longint p;
    int ph;
    bit st;
  } st_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic en[3];
  logic rst[3];
  obs_t obs[3];
  obs_t q[3][$];
  cfg_t cfg[3];
  st_t st[3];
  int errors = 0;
  int checks = 0;
  int fseq[$];
  bit fr_on = 1'b0;
  longint cyc = 0;
  longint last_fs = -1;
  vga_timing_gen_if #(.CW(10), .FW(8)) va();
  vga_timing_gen_if #(.CW(10), .FW(2)) vb();
  vga_timing_gen_if #(.CW(10), .FW(3)) vc();
  assign va.i_en = en[0];
  assign vb.i_en = en[1];
  assign vc.i_en = en[2];
  vga_timing_gen dut_a (.clk(clk), .rst_n(rst[0]), .vif(va.master));
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FW(2)
  ) dut_b (.clk(clk), .rst_n(rst[1]), .vif(vb.master));
  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .CW(10), .FW(3)
  ) dut_c (.clk(clk), .rst_n(rst[2]), .vif(vc.master));
  assign obs[0] = {va.o_pix_en, va.o_hs, va.o_vs, va.o_active, va.o_line_start, va.o_frame_start,
                   16'(va.o_x), 16'(va.o_y), 16'(va.o_frame)};
  assign obs[1] = {vb.o_pix_en, vb.o_hs, vb.o_vs, vb.o_active, vb.o_line_start, vb.o_frame_start,
                   16'(vb.o_x), 16'(vb.o_y), 16'(vb.o_frame)};
  assign obs[2] = {vc.o_pix_en, vc.o_hs, vc.o_vs, vc.o_active, vc.o_line_start, vc.o_frame_start,
                   16'(vc.o_x), 16'(vc.o_y), 16'(vc.o_frame)};
  // the raster position is just the number of pixel steps taken since reset
  function automatic obs_t model_out(cfg_t c, st_t s, bit e, bit r);
    obs_t o;
    int x, y;
    x = int'(s.p % c.ht);
    y = int'((s.p / c.ht) % c.vt);
    o.pe = r && e && s.ph == c.dv - 1;
    o.hs = (x >= c.hs0 && x < c.hs1) ? c.hp : ~c.hp;
    o.vs = (y >= c.vs0 && y < c.vs1) ? c.vp : ~c.vp;
    o.act = x < c.ha && y < c.va;
    o.ls = s.st && x == 0;
    o.fs = s.st && x == 0 && y == 0;
    o.x = 16'(x);
    o.y = 16'(y);
    o.fr = 16'(int'((s.p / (c.ht * c.vt)) % c.fm));
    return o;
  endfunction
  function automatic st_t model_step(cfg_t c, st_t s, bit e);
    st_t n = s;
    n.st = 1'b0;
    if (e) begin
      if (s.ph == c.dv - 1) begin
        n.p++;
        n.ph = 0;
        n.st = 1'b1;
      end else n.ph++;
    end
    return n;
  endfunction
  function automatic string fmt(obs_t o);
    return $sformatf("pe%0b hs%0b vs%0b act%0b ls%0b fs%0b x%0d y%0d fr%0d",
                     o.pe, o.hs, o.vs, o.act, o.ls, o.fs, o.x, o.y, o.fr);
  endfunction
  task automatic compare(int d, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL raster dut%0d t=%0t: got %s, expected %s", d, $time, fmt(got), fmt(exp));
    end
  endtask
  task automatic drive(int d, bit e);
    @(negedge clk);
    en[d] = e;
    q[d].push_back(model_out(cfg[d], st[d], e, rst[d]));
    if (rst[d]) st[d] = model_step(cfg[d], st[d], e);
  endtask
  task automatic release_rst(int d);
    #2 rst[d] = 1'b1;
    st[d] = model_step(cfg[d], st[d], en[d]);
  endtask
  task automatic async_rst(int d, int n);
    #2 rst[d] = 1'b0;
    st[d] = '{0, 0, 1'b0};
    q[d].push_back(model_out(cfg[d], st[d], en[d], 1'b0));
    repeat (n) drive(d, en[d]);
    release_rst(d);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial forever begin
      @(negedge clk or negedge rst[g]);
      #1;
      while (q[g].size() > 0) compare(g, obs[g], q[g].pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (fr_on && obs[1].fs) begin
      if (fseq.size() > 0) begin
        checks++;
        if (obs[1].fr != 16'(fseq[0])) begin
          errors++;
          $display("FAIL frame_seq: got o_frame=%0d, expected %0d", obs[1].fr, fseq[0]);
        end
        void'(fseq.pop_front());
      end
      if (last_fs >= 0) begin
        checks++;
        if (cyc - last_fs != 98) begin
          errors++;
          $display("FAIL frame_period: got %0d clk, expected 98", cyc - last_fs);
        end
      end
      last_fs = cyc;
    end
  end
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      en[d] = 1'b0;
      st[d] = '{0, 0, 1'b0};
    end
    cfg[0] = '{800, 525, 640, 480, 656, 752, 490, 492, 2, 256, 1'b0, 1'b0};
    cfg[1] = '{14, 7, 8, 4, 10, 12, 5, 6, 1, 4, 1'b1, 1'b1};
    cfg[2] = '{10, 7, 6, 3, 7, 9, 4, 5, 3, 8, 1'b0, 1'b0};
    fseq = '{1, 2, 3, 0, 1};
    repeat (2) drive(0, 1'b1);
    release_rst(0);
    while (st[0].p < 1900) drive(0, 1'b1);
    repeat (37) drive(0, 1'b0);
    while (st[0].p < 3100) drive(0, 1'b1);
    drive(0, 1'b1);
    async_rst(0, 3);
    repeat (2000) drive(0, $urandom_range(0, 9) != 0);
    repeat (2) drive(1, 1'b1);
    fr_on = 1'b1;
    release_rst(1);
    repeat (500) drive(1, 1'b1);
    fr_on = 1'b0;
    repeat (1000) drive(1, $urandom_range(0, 2) != 0);
    async_rst(1, 2);
    repeat (200) drive(1, 1'b1);
    repeat (2) drive(2, 1'b0);
    release_rst(2);
    repeat (2500) drive(2, $urandom_range(0, 3) != 0);
    async_rst(2, $urandom_range(1, 4));
    repeat (2500) drive(2, $urandom_range(0, 3) != 0);
    @(negedge clk);
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d pending, expected 0", d, q[d].size());
      end
    end
    checks++;
    if (fseq.size() != 0) begin
      errors++;
      $display("FAIL frame_seq_count: got %0d frame starts missing, expected 0", fseq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
